cnt_arb_ctrl: RTL
=================

# cnt_arb_ctrl

Two-port arbiter and sequencer for the 8-bit up/down counter datapath. It accepts counter commands from two requesters, grants the counter to one of them by round-robin, and drives the counter's `en`/`load`/`updown`/`in_data` pins to run the command. It then returns the final `out_data` to the winning requester. It sits between the requesters and the counter, and it is the only driver of the counter control pins.

## Interface
- `DATA_W`, 8: counter data width; also the width of each `req_data` slice and of `rsp_data`.
- `STEP_W`, 8: width of the step count in each `req_steps` slice.
- `clk`  in  1  clock; all logic on posedge.
- `rst`  in  1  reset, synchronous, active-high.
- `req_valid`  in  2  bit i is high when requester i presents a command.
- `req_ready`  out  2  bit i is high when command i is accepted this cycle (handshake = valid & ready).
- `req_load`  in  2  bit i set: load `req_data[i]` before counting.
- `req_updown`  in  2  bit i: 1 counts up, 0 counts down.
- `req_data`  in  2*DATA_W  slice i is the load value.
- `req_steps`  in  2*STEP_W  slice i is the number of enable cycles (0..255).
- `rsp_valid`  out  2  one-hot, 1-cycle pulse to the requester that owned the command.
- `rsp_data`  out  DATA_W  counter value at completion; valid with `rsp_valid`.
- `cnt_en`, `cnt_load`, `cnt_updown`  out  1 each  counter controls.
- `cnt_in_data`  out  DATA_W  counter load value.
- `cnt_out_data`  in  DATA_W  counter registered output.
- `busy`  out  1  high whenever the FSM is not in IDLE.

## Operation
- Counter contract: on a posedge, `load`=1 sets out <= in_data. Otherwise `en`=1 counts out±1 modulo 2^DATA_W (up when `updown`=1). `load` has priority over `en`. The new value is visible the following cycle.
- FSM states: IDLE, LOAD, COUNT, DONE.
- IDLE:
  - Round-robin grant with a 1-bit priority pointer `prio`, reset to 0.
  - Both valid: grant `prio`. One valid: grant that one. None valid: stay.
  - `req_ready[g]`=1 for the granted g only; this is combinational from `req_valid` and state.
  - On handshake, capture load/updown/data/steps of g, record the owner, and set `prio` <= ~g.
  - Next state: LOAD if load=1; otherwise COUNT if steps≠0; otherwise DONE.
- LOAD (1 cycle): `cnt_load`=1, `cnt_in_data`=captured data, `cnt_en`=0. Next state is COUNT if steps≠0, else DONE.
- COUNT: `cnt_en`=1 and `cnt_updown`=captured updown. A remaining-step counter decrements each cycle. Exit to DONE after exactly `steps` cycles.
- DONE (1 cycle): register `rsp_data` <= `cnt_out_data` and set `rsp_valid` <= one-hot(owner), then go to IDLE.
- `rsp_valid` is high for exactly one cycle, in the first IDLE cycle after DONE. A new grant may occur in that same cycle.
- Outside LOAD, `cnt_load`=0. Outside COUNT, `cnt_en`=0. `cnt_in_data` and `cnt_updown` hold the captured values (0 after reset).
- No saturation: the counter wraps 0xFF->0x00 going up and 0x00->0xFF going down. Arithmetic belongs entirely to the counter.
- Requesters must hold the command stable while valid and not ready. The block never accepts while `busy`=1.

## Timing
- Reset (any state): state=IDLE and `prio`=0. `req_ready`, `rsp_valid`, `cnt_en`, `cnt_load`, `cnt_updown`, `busy` are 0; `cnt_in_data`=0; `rsp_data`=0.
- Reset mid-command: the command is discarded, no `rsp_valid` is issued, and the counter stops receiving en/load the cycle after reset is sampled.
- Handshake at cycle T. Let N = steps.
  - load=1: LOAD at T+1, COUNT at T+2..T+1+N, DONE at T+2+N, `rsp_valid` at T+3+N.
  - load=0, N>0: COUNT at T+1..T+N, DONE at T+N+1, `rsp_valid` at T+N+2.
  - load=0, N=0: readback; DONE at T+1, `rsp_valid` at T+2.
- Minimum spacing between handshakes: 2 cycles (readback).
- `busy` is high from T+1 through the DONE cycle inclusive.

## Test plan
- Reset, then req0: load=1, data=0x10, up, steps=5 -> exactly 1 `cnt_load` cycle and 5 `cnt_en` cycles; `rsp_valid`=01 with `rsp_data`=0x15 at T+8.
- req1: load=1, data=0x02, down, steps=4 -> `rsp_valid`=10 with `rsp_data`=0xFE (wrap-around).
- req0 and req1 both valid continuously -> grants alternate 0,1,0,1 starting with 0 after reset; each `rsp_valid` goes to the matching owner.
- req0: load=0, steps=0 with the counter at 0xA5 -> no en/load pulses; `rsp_valid`=01 and `rsp_data`=0xA5 at T+2.
- load=1, data=0xFF, up, steps=255 -> `rsp_data`=0xFE, with 255 consecutive `cnt_en` cycles.
- Assert `rst` during COUNT of a steps=10 command -> outputs are at reset values the next cycle, no `rsp_valid` is ever issued, and the next grant goes to requester 0.

Source files
------------

// File: rtl/cnt_arb_ctrl_if.sv
// Requester-side bus of the counter arbiter: two command slots plus the shared response.
// The requester block holds the master modport; the arbiter holds the slave modport.
interface cnt_arb_ctrl_if #(
    parameter int DATA_W = 8,
    parameter int STEP_W = 8
);
    logic [1:0]             req_valid;
    logic [1:0]             req_ready;
    logic [1:0]             req_load;
    logic [1:0]             req_updown;
    logic [1:0][DATA_W-1:0] req_data;
    logic [1:0][STEP_W-1:0] req_steps;
    logic [1:0]             rsp_valid;
    logic [DATA_W-1:0]      rsp_data;

    modport master (
        output req_valid, req_load, req_updown, req_data, req_steps,
        input  req_ready, rsp_valid, rsp_data
    );

    modport slave (
        input  req_valid, req_load, req_updown, req_data, req_steps,
        output req_ready, rsp_valid, rsp_data
    );
endinterface

// File: rtl/cnt_arb_ctrl.sv
// Round-robin arbiter/sequencer for two requesters sharing one up/down counter:
// grants a command, drives load/en for it, then returns the final count to its owner.
module cnt_arb_ctrl #(
    parameter int DATA_W = 8,
    parameter int STEP_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    cnt_arb_ctrl_if.slave     bus,
    output logic              cnt_en,
    output logic              cnt_load,
    output logic              cnt_updown,
    output logic [DATA_W-1:0] cnt_in_data,
    input  logic [DATA_W-1:0] cnt_out_data,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, LOAD, COUNT, DONE} state_t;

    typedef struct packed {
        logic              load;
        logic              updown;
        logic [DATA_W-1:0] data;
        logic [STEP_W-1:0] steps;
    } cmd_t;

    state_t            state;
    logic              prio;
    logic              owner;
    logic [STEP_W-1:0] rem;
    logic              g;
    cmd_t              sel;

    // Grant pick: contested -> prio, otherwise whichever is asking.
    always_comb begin
        g   = (&bus.req_valid) ? prio : bus.req_valid[1];
        sel = '{load:   bus.req_load[g],
                updown: bus.req_updown[g],
                data:   bus.req_data[g],
                steps:  bus.req_steps[g]};
        bus.req_ready = (!rst && state == IDLE && |bus.req_valid) ? (2'b01 << g) : 2'b00;
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            prio          <= 1'b0;
            owner         <= 1'b0;
            rem           <= '0;
            cnt_en        <= 1'b0;
            cnt_load      <= 1'b0;
            cnt_updown    <= 1'b0;
            cnt_in_data   <= '0;
            bus.rsp_valid <= 2'b00;
            bus.rsp_data  <= '0;
        end else begin
            bus.rsp_valid <= 2'b00;
            case (state)
                IDLE: begin
                    if (|bus.req_valid) begin
                        owner       <= g;
                        prio        <= ~g;
                        rem         <= sel.steps;
                        cnt_updown  <= sel.updown;
                        cnt_in_data <= sel.data;
                        if (sel.load) begin
                            state    <= LOAD;
                            cnt_load <= 1'b1;
                        end else if (sel.steps != '0) begin
                            state  <= COUNT;
                            cnt_en <= 1'b1;
                        end else begin
                            state <= DONE;
                        end
                    end
                end
                LOAD: begin
                    cnt_load <= 1'b0;
                    if (rem != '0) begin
                        state  <= COUNT;
                        cnt_en <= 1'b1;
                    end else begin
                        state <= DONE;
                    end
                end
                // rem holds the cycles still to run including this one.
                COUNT: begin
                    if (rem == STEP_W'(1)) begin
                        state  <= DONE;
                        cnt_en <= 1'b0;
                    end else begin
                        rem <= rem - STEP_W'(1);
                    end
                end
                DONE: begin
                    bus.rsp_data  <= cnt_out_data;
                    bus.rsp_valid <= 2'b01 << owner;
                    state         <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
